// File: rtl/pc_branch_ctrl.sv
// Program counter and branch resolution: picks the next PC, opens a
// flush window on every redirect, traps misaligned targets, counts redirects.
//   clk, rst_n          clock, async active-low reset
//   stall               hold all state this cycle (trap forced low)
//   pc_op, cmp_b        00 SEQ, 01 BRANCH, 10 JAL, 11 JALR; branch condition
//   imm, rs1_d          sign-extended immediate, JALR base register
//   pc, pc_plus4        current fetch PC, link value
//   flush, trap         squash window, misaligned-target trap pulse
//   trap_pc, redir_cnt  PC of last trapping instruction, saturating count
module pc_branch_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VEC    = '0,
    parameter logic [XLEN-1:0] TRAP_VEC     = 'h10,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic [1:0]      pc_op,
    input  logic            cmp_b,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_d,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            flush,
    output logic            trap,
    output logic [XLEN-1:0] trap_pc,
    output logic [15:0]     redir_cnt
);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    localparam logic [3:0] FC_M1 = 4'(FLUSH_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] tpc_q, tpc_d;
    logic [15:0]     redir_q, redir_d;

    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] tgt;
    logic            taken;
    logic            misal;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign jalr_sum = rs1_d + imm;

    always_comb begin
        tgt   = pc_q + imm;
        if (pc_op == 2'b11) begin
            tgt = {jalr_sum[XLEN-1:1], 1'b0};
        end
        taken = (pc_op == 2'b01) ? cmp_b : (pc_op != 2'b00);
        misal = taken & (tgt[1] | tgt[0]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        flush_d = flush_q;
        trap_d  = 1'b0;
        tpc_d   = tpc_q;
        redir_d = redir_q;
        if (!stall) begin
            unique case (state_q)
                RUN: begin
                    if (misal) begin
                        pc_d    = TRAP_VEC;
                        tpc_d   = pc_q;
                        trap_d  = 1'b1;
                        flush_d = 1'b1;
                        cnt_d   = FC_M1;
                        state_d = FLUSH;
                    end else if (taken) begin
                        pc_d    = tgt;
                        flush_d = 1'b1;
                        cnt_d   = FC_M1;
                        state_d = FLUSH;
                        if (redir_q != 16'hFFFF) begin
                            redir_d = redir_q + 16'd1;
                        end
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
                FLUSH: begin
                    pc_d = pc_plus4;
                    if (cnt_q == 4'd0) begin
                        flush_d = 1'b0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            pc_q    <= RESET_VEC;
            flush_q <= 1'b0;
            trap_q  <= 1'b0;
            tpc_q   <= '0;
            redir_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            trap_q  <= trap_d;
            tpc_q   <= tpc_d;
            redir_q <= redir_d;
        end
    end

    assign pc        = pc_q;
    assign flush     = flush_q;
    assign trap      = trap_q;
    assign trap_pc   = tpc_q;
    assign redir_cnt = redir_q;

endmodule
